// File: rtl/msg_pkg.sv
// msg_pkg: shared message layout, sizes and FSM state encoding for the message transmitter.
//   MSG_W  - message width in bits
//   BYTE_W - link byte width
//   NBYTES - bytes per message
//   msg_t  - packed message fields, MSB first
//   state_t - transmitter FSM states
package msg_pkg;
  localparam int MSG_W = 168;
  localparam int BYTE_W = 8;
  localparam int NBYTES = MSG_W / BYTE_W;
  typedef struct packed {
    logic [23:0] sync;
    logic [31:0] id;
    logic [31:0] code;
    logic [31:0] arg;
    logic [7:0]  flag;
    logic [31:0] seq;
    logic [7:0]  tail;
  } msg_t;
  typedef enum logic [1:0] {IDLE, SEND, CSUM, GAP} state_t;
endpackage

// File: rtl/msg_frame_tx_csum.sv
// msg_csum_acc: mod-256 byte accumulator whose output is the two's-complement checksum byte.
//   clk, rst_n - clock and synchronous active-low reset
//   clr        - zero the running sum (start of frame)
//   add        - add din into the running sum
//   din        - byte to accumulate
//   neg        - (~sum + 1), the byte that brings the frame sum to zero
module msg_csum_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic [7:0] neg
);
  logic [7:0] sum_q, sum_d;
  always_comb sum_d = clr ? 8'd0 : add ? sum_q + din : sum_q;
  always_ff @(posedge clk)
    if (!rst_n) sum_q <= '0;
    else sum_q <= sum_d;
  assign neg = ~sum_q + 8'd1;
endmodule

// File: rtl/msg_frame_tx.sv
// msg_frame_tx: accepts one packed message over valid/ready and serialises it MSB-first as bytes.
//   clk, rst_n         - clock and synchronous active-low reset
//   in_valid/in_ready  - message handshake, in_msg holds the packed msg_pkg::msg_t
//   tx_valid/tx_ready  - byte handshake, tx_data is the current byte, tx_last marks the final byte
//   busy               - high whenever the FSM is not IDLE
//   frame_cnt          - completed frames, wraps modulo 2^CNT_W
//   Define MSG_TX_CHECKSUM_EN to append a checksum byte that zeroes the frame's mod-256 sum.
module msg_frame_tx #(
  parameter int MSG_W      = 168,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_msg,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);
  import msg_pkg::*;
  localparam int NB = MSG_W / BYTE_W;
  localparam int IW = $clog2(NB + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
`ifdef MSG_TX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [MSG_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] csum;
  logic acc, last_byte, done;
  assign acc = tx_valid && tx_ready;
  assign last_byte = idx_q == IW'(NB - 1);
  // a frame completes on acceptance of its final byte: checksum if enabled, else message byte NB-1
  assign done = acc && (state_q == CSUM || (state_q == SEND && last_byte && !CSUM_EN));
`ifdef MSG_TX_CHECKSUM_EN
  msg_csum_acc u_csum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE && in_valid),
    .add  (acc && state_q == SEND),
    .din  (shreg_q[MSG_W-1 -: 8]),
    .neg  (csum)
  );
`else
  assign csum = '0;
`endif
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d = idx_q;
    gap_d = gap_q;
    cnt_d = done ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SEND;
        shreg_d = in_msg;
        idx_d = '0;
      end
      SEND: if (tx_ready) begin
        shreg_d = shreg_q << BYTE_W;
        idx_d = idx_q + 1'b1;
        if (last_byte) state_d = CSUM_EN ? CSUM : GAP_CYCLES > 0 ? GAP : IDLE;
      end
      CSUM: if (tx_ready) state_d = GAP_CYCLES > 0 ? GAP : IDLE;
      default: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          gap_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q <= '0;
      gap_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      cnt_q <= cnt_d;
    end
  // in_ready is held low while reset is asserted, before the state register has been cleared
  assign in_ready = rst_n && state_q == IDLE;
  assign tx_valid = state_q == SEND || state_q == CSUM;
  assign tx_data = state_q == SEND ? shreg_q[MSG_W-1 -: 8] : state_q == CSUM ? csum : 8'd0;
  assign tx_last = tx_valid && (state_q == CSUM || (last_byte && !CSUM_EN));
  assign busy = state_q != IDLE;
  assign frame_cnt = cnt_q;
endmodule

// File: tb/tb_msg_frame_tx.sv
// tb_msg_frame_tx: scoreboard bench for msg_frame_tx, default instance plus a GAP_CYCLES=4/CNT_W=2 instance.
module tb_msg_frame_tx;
`ifdef MSG_TX_CHECKSUM_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  typedef struct {
    logic [167:0] msg;
    logic [7:0]   cs;
  } vec_t;
  logic clk = 0, rst_n = 0;
  logic a_in_valid = 0, a_in_ready, a_tx_valid, a_tx_ready = 1, a_tx_last, a_busy;
  logic [167:0] a_in_msg = '0;
  logic [7:0] a_tx_data, a_cs = '0;
  logic [15:0] a_frame_cnt;
  logic b_in_valid = 0, b_in_ready, b_tx_valid, b_tx_ready = 1, b_tx_last, b_busy;
  logic [167:0] b_in_msg = '0;
  logic [7:0] b_tx_data, b_cs = '0;
  logic [1:0] b_frame_cnt;
  logic [8:0] qa[$], qb[$];
  logic [8:0] ea, eb;
  int checks = 0, errors = 0;
  always #10 clk = ~clk;

  msg_frame_tx u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_msg(a_in_msg),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_data(a_tx_data), .tx_last(a_tx_last),
    .busy(a_busy), .frame_cnt(a_frame_cnt)
  );
  msg_frame_tx #(.GAP_CYCLES(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_msg(b_in_msg),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data), .tx_last(b_tx_last),
    .busy(b_busy), .frame_cnt(b_frame_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_in_valid && a_in_ready) begin
        for (int i = 0; i < 21; i++) qa.push_back({a_in_msg[167-8*i -: 8], !EN && i == 20});
        if (EN) qa.push_back({a_cs, 1'b1});
      end
      if (a_tx_valid && a_tx_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_extra_byte got=%0h want=none", a_tx_data);
        end else begin
          ea = qa.pop_front();
          chk("a_data", a_tx_data, ea[8:1]);
          chk("a_last", a_tx_last, ea[0]);
        end
      end
      if (b_in_valid && b_in_ready) begin
        for (int i = 0; i < 21; i++) qb.push_back({b_in_msg[167-8*i -: 8], !EN && i == 20});
        if (EN) qb.push_back({b_cs, 1'b1});
      end
      if (b_tx_valid && b_tx_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_extra_byte got=%0h want=none", b_tx_data);
        end else begin
          eb = qb.pop_front();
          chk("b_data", b_tx_data, eb[8:1]);
          chk("b_last", b_tx_last, eb[0]);
        end
      end
    end
  end

  // drive a message and return at posedge+1 just after it is accepted (byte 0 on the bus)
  task automatic send_a(input logic [167:0] m, input logic [7:0] cs);
    int n = 0;
    @(posedge clk);
    #1;
    a_in_msg = m;
    a_cs = cs;
    a_in_valid = 1;
    while (!a_in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("a_accept_timeout", n < 50, 1);
    @(posedge clk);
    #1;
    a_in_valid = 0;
  endtask

  // drain the scoreboard, then confirm the block is idle and ready the very next cycle
  task automatic wait_a();
    int n = 0;
    while (qa.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("a_drain_timeout", n < 200, 1);
    @(negedge clk);
    #1;
    chk("a_ready_after", a_in_ready, 1);
    chk("a_busy_after", a_busy, 0);
    chk("a_valid_after", a_tx_valid, 0);
  endtask

  initial begin
    vec_t vt[5];
    logic [167:0] inc;
    int fa = 0, n, g;
    logic [1:0] bseq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 21; i++) inc[167-8*i -: 8] = 8'(i + 1);
    vt[0] = '{{24'd0, 32'd1, 32'd96, 32'd0, 8'd0, 32'd0, 8'd0}, 8'h9F};
    vt[1] = '{{24'd0, 32'd1, 32'd104, 32'd0, 8'd1, 32'd1, 8'd0}, 8'h95};
    vt[2] = '{{21{8'hFF}}, 8'h15};
    vt[3] = '{inc, 8'h19};
    vt[4] = '{{21{8'hA5}}, 8'h77};
    @(negedge clk);
    #1;
    chk("rst_in_ready", a_in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    #1;
    chk("rst_in_ready_after", a_in_ready, 1);
    chk("rst_tx_valid", a_tx_valid, 0);
    chk("rst_tx_data", a_tx_data, 0);
    chk("rst_tx_last", a_tx_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_frame_cnt", a_frame_cnt, 0);
    chk("rst_b_frame_cnt", b_frame_cnt, 0);
    // reset mid-frame once bytes 0..7 have been accepted
    send_a(inc, 8'h19);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_byte8_present", a_tx_data, 8'h09);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    qa.delete();
    @(negedge clk);
    #1;
    chk("abort_tx_valid", a_tx_valid, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_frame_cnt", a_frame_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      send_a(vt[k].msg, vt[k].cs);
      wait_a();
      fa++;
      chk("a_frame_cnt", a_frame_cnt, fa);
    end
    // backpressure on byte 5 for three cycles
    send_a(inc, 8'h19);
    repeat (5) @(posedge clk);
    #1;
    a_tx_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", a_tx_valid, 1);
      chk("bp_data", a_tx_data, 8'h06);
      chk("bp_last", a_tx_last, 0);
    end
    @(posedge clk);
    #1;
    a_tx_ready = 1;
    wait_a();
    fa++;
    chk("bp_frame_cnt", a_frame_cnt, fa);
    // GAP_CYCLES=4, CNT_W=2 with in_valid held: five frames
    @(posedge clk);
    #1;
    b_in_msg = vt[0].msg;
    b_cs = vt[0].cs;
    b_in_valid = 1;
    @(negedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (qb.size() != 0 && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("b_drain_timeout", n < 200, 1);
      if (k == 4) b_in_valid = 0;
      g = 0;
      @(negedge clk);
      #1;
      while (!b_in_ready && g < 20) begin
        chk("b_gap_valid", b_tx_valid, 0);
        g++;
        @(negedge clk);
        #1;
      end
      chk("b_gap_len", g, 4);
      chk("b_frame_cnt", b_frame_cnt, bseq[k]);
    end
    chk("b_idle_busy", b_busy, 0);
    repeat (3) @(negedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
